// File: rtl/timer_device.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes.
// Registers: CTRL (Enable, Mode, IM), PRESET, COUNT; IRQ = IM & pending.
module timer_device (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count, count_nxt;
    logic        pending;
    logic        pending_set, pending_fsm_clr, en_clr;
    logic        enable, auto_reload;
    logic        wr_ctrl, wr_preset;

    assign enable      = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign wr_ctrl     = We && (Addr == 2'b00);
    assign wr_preset   = We && (Addr == 2'b01);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        count_nxt       = count;
        pending_set     = 1'b0;
        pending_fsm_clr = 1'b0;
        en_clr          = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = LOAD;
            end
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (count <= 32'd1) begin
                    count_nxt   = '0;
                    pending_set = 1'b1;
                    state_nxt   = INT;
                end else begin
                    count_nxt = count - 32'd1;
                end
            end
            INT: begin
                if (auto_reload) begin
                    pending_fsm_clr = 1'b1;
                    state_nxt       = LOAD;
                end else begin
                    en_clr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // CPU writes to CTRL take priority over the one-shot Enable auto-clear;
    // a pending set on the same edge as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= Din[3:0];
            end else if (en_clr) begin
                ctrl[0] <= 1'b0;
            end
            if (wr_preset) begin
                preset <= Din;
            end
            count <= count_nxt;
            if (pending_set) begin
                pending <= 1'b1;
            end else if (wr_ctrl || wr_preset || pending_fsm_clr) begin
                pending <= 1'b0;
            end
        end
    end

    assign IRQ = ctrl[3] & pending;

    always_comb begin
        Dout = '0;
        case (Addr)
            2'b00:   Dout = {28'd0, ctrl};
            2'b01:   Dout = preset;
            2'b10:   Dout = count;
            default: Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_device.sv
// Directed self-checking bench for timer_device; inputs change on the falling
// edge, outputs are checked during the low phase of clk.
module tb_timer_device;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int unsigned total = 0;
    int unsigned bad   = 0;

    timer_device dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .We    (We),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write lands on the rising edge after the next falling edge; returns on the
    // falling edge that follows it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a;
        Din  = d;
        We   = 1'b1;
        @(negedge clk);
        We   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(tag, Dout, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        Addr  = 2'b00;
        We    = 1'b0;
        Din   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset values
        rd_chk("rst_ctrl", 2'b00, 32'h0);
        rd_chk("rst_preset", 2'b01, 32'h0);
        rd_chk("rst_count", 2'b10, 32'h0);
        check("rst_irq", {31'd0, IRQ}, 32'd0);

        // one-shot, PRESET=5
        wr(2'b01, 32'd5);
        rd_chk("os_preset", 2'b01, 32'd5);
        wr(2'b00, 32'h9);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rd_chk("os_count", 2'b10, 32'(5 - i));
            check("os_irq", {31'd0, IRQ}, (i == 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        rd_chk("os_ctrl_after", 2'b00, 32'h8);
        check("os_irq_held", {31'd0, IRQ}, 32'd1);
        repeat (3) @(negedge clk);
        check("os_irq_still", {31'd0, IRQ}, 32'd1);
        wr(2'b00, 32'h8);
        check("os_irq_cleared", {31'd0, IRQ}, 32'd0);

        // auto-reload, PRESET=3: pulses every 5 cycles
        wr(2'b01, 32'd3);
        wr(2'b00, 32'hB);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            check("ar_irq", {31'd0, IRQ}, (k % 5 == 0) ? 32'd1 : 32'd0);
        end
        rd_chk("ar_ctrl", 2'b00, 32'hB);
        wr(2'b00, 32'h0);
        repeat (6) @(negedge clk);
        check("ar_stop_irq", {31'd0, IRQ}, 32'd0);

        // masked interrupt, PRESET=2
        wr(2'b01, 32'd2);
        wr(2'b00, 32'h1);
        repeat (6) @(negedge clk);
        rd_chk("mk_count", 2'b10, 32'd0);
        check("mk_irq", {31'd0, IRQ}, 32'd0);
        rd_chk("mk_ctrl", 2'b00, 32'h0);
        wr(2'b00, 32'h8);
        check("mk_irq_after_im", {31'd0, IRQ}, 32'd0);
        @(negedge clk);
        check("mk_irq_after_im2", {31'd0, IRQ}, 32'd0);

        // disable freezes count, ignored writes, re-enable reloads
        wr(2'b01, 32'd10);
        wr(2'b00, 32'h1);
        repeat (5) @(negedge clk);
        rd_chk("ds_count_pre", 2'b10, 32'd7);
        wr(2'b00, 32'h0);
        rd_chk("ds_count_frozen", 2'b10, 32'd5);
        repeat (3) @(negedge clk);
        rd_chk("ds_count_hold", 2'b10, 32'd5);
        wr(2'b10, 32'h1234);
        rd_chk("ds_count_wr", 2'b10, 32'd5);
        wr(2'b11, 32'hFFFF_FFFF);
        rd_chk("ds_reserved", 2'b11, 32'h0);
        wr(2'b00, 32'hFFFF_FFF1);
        rd_chk("ds_ctrl_upper", 2'b00, 32'h1);
        repeat (2) @(negedge clk);
        rd_chk("ds_reload", 2'b10, 32'd10);
        @(negedge clk);
        rd_chk("ds_reload_dec", 2'b10, 32'd9);

        // zero preset behaves like one
        wr(2'b00, 32'h0);
        repeat (2) @(negedge clk);
        wr(2'b01, 32'd0);
        wr(2'b00, 32'h9);
        @(negedge clk);
        check("zp_irq1", {31'd0, IRQ}, 32'd0);
        @(negedge clk);
        check("zp_irq2", {31'd0, IRQ}, 32'd0);
        @(negedge clk);
        check("zp_irq3", {31'd0, IRQ}, 32'd1);
        @(negedge clk);
        rd_chk("zp_ctrl", 2'b00, 32'h8);

        // asynchronous reset while IRQ is high
        #1 reset = 1'b1;
        #1 check("rsA_irq", {31'd0, IRQ}, 32'd0);
        rd_chk("rsA_ctrl", 2'b00, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // asynchronous reset mid-count
        wr(2'b01, 32'd7);
        wr(2'b00, 32'h9);
        repeat (5) @(negedge clk);
        rd_chk("rsB_count_pre", 2'b10, 32'd4);
        #1 reset = 1'b1;
        rd_chk("rsB_count", 2'b10, 32'h0);
        rd_chk("rsB_ctrl", 2'b00, 32'h0);
        rd_chk("rsB_preset", 2'b01, 32'h0);
        check("rsB_irq", {31'd0, IRQ}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wr(2'b01, 32'd3);
        repeat (4) @(negedge clk);
        rd_chk("rsB_idle_count", 2'b10, 32'h0);
        check("rsB_idle_irq", {31'd0, IRQ}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
